// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: registered RISC-V immediate generator behind a 2-entry skid buffer; IMM_GEN_CSR_EN enables the Z (CSR zimm) select.
module imm_gen_pipe #(
  parameter int INST_WIDTH    = 32,
  parameter int IMM_SEL_WIDTH = 3,
  parameter int XLEN          = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [INST_WIDTH-1:0]    inst,
  input  logic [IMM_SEL_WIDTH-1:0] imm_sel,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [XLEN-1:0]          imm_out,
  output logic                     imm_err
);
`ifdef IMM_GEN_CSR_EN
  localparam int MAX_SEL = 5;
`else
  localparam int MAX_SEL = 4;
`endif
  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;
  state_t state, nxt;
  logic [XLEN-1:0] gen_imm, skid_imm;
  logic [31:0] sel;
  logic gen_err, skid_err, acc, pop, unused;
  assign unused = ^inst[6:0];
  assign sel = 32'(imm_sel);
  assign gen_err = sel > MAX_SEL;
  assign acc = in_valid & in_ready;
  assign pop = out_valid & out_ready;
  always_comb begin
    gen_imm = sel == 0 ? XLEN'($signed(inst[31:20])) :
              sel == 1 ? XLEN'($signed({inst[31:25], inst[11:7]})) :
              sel == 2 ? XLEN'($signed({inst[31], inst[7], inst[30:25], inst[11:8], 1'b0})) :
              sel == 3 ? XLEN'($signed({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0})) :
              sel == 4 ? XLEN'($signed({inst[31:12], 12'b0})) :
              sel == 5 && !gen_err ? XLEN'(inst[19:15]) : '0;
    nxt = flush ? EMPTY :
          state == EMPTY ? (acc ? ONE : EMPTY) :
          state == ONE ? (pop && !acc ? EMPTY : acc && !pop ? FULL : ONE) :
          (pop ? ONE : FULL);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= EMPTY;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
      imm_out   <= '0;
      imm_err   <= 1'b0;
      skid_imm  <= '0;
      skid_err  <= 1'b0;
    end else begin
      state     <= nxt;
      out_valid <= nxt != EMPTY;
      in_ready  <= nxt != FULL;
      if (!flush && acc && (state == EMPTY || pop)) begin
        imm_out <= gen_imm;
        imm_err <= gen_err;
      end else if (!flush && pop && state == FULL) begin
        imm_out <= skid_imm;
        imm_err <= skid_err;
      end
      if (!flush && acc && !pop && state == ONE) begin
        skid_imm <= gen_imm;
        skid_err <= gen_err;
      end
    end
  end
endmodule

// File: tb/tb_imm_gen_pipe.sv
// tb_imm_gen_pipe: directed and random checks of imm_gen_pipe at XLEN=32 and XLEN=64 against a FIFO reference model.
module tb_imm_gen_pipe;
  logic clk = 1'b0, rst_n = 1'b0, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [31:0] inst = '0;
  logic [2:0] imm_sel = '0;
  logic in_ready32, out_valid32, err32, in_ready64, out_valid64, err64;
  logic [31:0] imm32;
  logic [63:0] imm64;
  int checks = 0, errors = 0;
  typedef struct {logic [63:0] v; logic e;} ent_t;
  ent_t q[$];

  imm_gen_pipe #(.XLEN(32)) dut32 (.clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid),
    .in_ready(in_ready32), .inst(inst), .imm_sel(imm_sel), .out_valid(out_valid32),
    .out_ready(out_ready), .imm_out(imm32), .imm_err(err32));
  imm_gen_pipe #(.XLEN(64)) dut64 (.clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid),
    .in_ready(in_ready64), .inst(inst), .imm_sel(imm_sel), .out_valid(out_valid64),
    .out_ready(out_ready), .imm_out(imm64), .imm_err(err64));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic ent_t ref_imm(input logic [31:0] i, input logic [2:0] s);
    ent_t r;
    longint si = longint'($signed(i));
    longint sg = si >>> 31;
    r.e = 1'b0;
    case (s)
      3'd0: r.v = si >>> 20;
      3'd1: r.v = ((si >>> 25) << 5) | longint'(i[11:7]);
      3'd2: r.v = (sg << 12) | (longint'(i[7]) << 11) | (longint'(i[30:25]) << 5) | (longint'(i[11:8]) << 1);
      3'd3: r.v = (sg << 20) | (longint'(i[19:12]) << 12) | (longint'(i[20]) << 11) | (longint'(i[30:21]) << 1);
      3'd4: r.v = si & ~longint'(12'hFFF);
`ifdef IMM_GEN_CSR_EN
      3'd5: r.v = longint'(i[19:15]);
`endif
      default: begin r.v = 0; r.e = 1'b1; end
    endcase
    return r;
  endfunction

  task automatic check_state(input string tag);
    chk({tag, ".out_valid32"}, 64'(out_valid32), 64'(q.size() > 0));
    chk({tag, ".out_valid64"}, 64'(out_valid64), 64'(q.size() > 0));
    chk({tag, ".in_ready32"}, 64'(in_ready32), 64'(q.size() < 2));
    chk({tag, ".in_ready64"}, 64'(in_ready64), 64'(q.size() < 2));
    if (q.size() > 0) begin
      chk({tag, ".imm32"}, 64'(imm32), 64'(q[0].v[31:0]));
      chk({tag, ".imm64"}, imm64, q[0].v);
      chk({tag, ".err32"}, 64'(err32), 64'(q[0].e));
      chk({tag, ".err64"}, 64'(err64), 64'(q[0].e));
    end
  endtask

  // Drive one cycle, check outputs mid-cycle, then advance the model across the edge.
  task automatic cyc(input logic iv, input logic [31:0] ins, input logic [2:0] s, input logic ordy, input logic fl);
    logic pop, acc;
    in_valid = iv; inst = ins; imm_sel = s; out_ready = ordy; flush = fl;
    @(negedge clk);
    check_state("cyc");
    pop = q.size() > 0 && ordy;
    acc = iv && q.size() < 2;
    @(posedge clk);
    if (fl) q.delete();
    else begin
      if (pop) void'(q.pop_front());
      if (acc) q.push_back(ref_imm(ins, s));
    end
    #1;
  endtask

  task automatic check_reset(input string tag);
    chk({tag, ".out_valid"}, 64'(out_valid32 | out_valid64), 64'(0));
    chk({tag, ".imm32"}, 64'(imm32), 64'(0));
    chk({tag, ".imm64"}, imm64, 64'(0));
    chk({tag, ".err"}, 64'(err32 | err64), 64'(0));
    chk({tag, ".in_ready"}, 64'(in_ready32 & in_ready64), 64'(1));
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 check_reset("reset");
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk) #1;
    check_reset("post_reset");
    cyc(1, 32'hFFF00093, 3'd0, 1, 0);
    chk("I_const", 64'(imm32), 64'hFFFFFFFF);
    chk("I_err", 64'(err32), 64'(0));
    cyc(1, 32'hFE20AE23, 3'd1, 1, 0);
    chk("S_const", 64'(imm32), 64'hFFFFFFFC);
    cyc(1, 32'h123452B7, 3'd4, 1, 0);
    chk("U_const", 64'(imm32), 64'h12345000);
    cyc(1, 32'h001000EF, 3'd3, 1, 0);
    chk("J_const", 64'(imm32), 64'h00000800);
    cyc(1, 32'h800002B7, 3'd4, 1, 0);
    chk("U64_const", imm64, 64'hFFFFFFFF80000000);
    cyc(1, 32'hFFFFFFFF, 3'd6, 1, 0);
    chk("sel6_imm", 64'(imm32), 64'(0));
    chk("sel6_err", 64'(err32), 64'(1));
    cyc(1, 32'h000F8073, 3'd5, 1, 0);
`ifdef IMM_GEN_CSR_EN
    chk("Z_imm", 64'(imm32), 64'h1F);
    chk("Z_err", 64'(err32), 64'(0));
`else
    chk("Z_imm", 64'(imm32), 64'(0));
    chk("Z_err", 64'(err32), 64'(1));
`endif
    cyc(0, 0, 0, 1, 0);
    cyc(1, 32'h00100093, 3'd0, 0, 0);
    cyc(1, 32'h00200023, 3'd1, 0, 0);
    chk("bp_in_ready", 64'(in_ready32), 64'(0));
    cyc(1, 32'hFE000EE3, 3'd2, 0, 0);
    cyc(1, 32'hFE000EE3, 3'd2, 0, 0);
    cyc(1, 32'hFE000EE3, 3'd2, 1, 0);
    cyc(1, 32'hFE000EE3, 3'd2, 1, 0);
    cyc(0, 0, 0, 1, 0);
    chk("bp_drained", 64'(out_valid32), 64'(0));
    cyc(1, 32'hABCDE0B7, 3'd4, 0, 0);
    cyc(1, 32'h7FF00093, 3'd0, 0, 0);
    cyc(1, 32'h80000037, 3'd4, 0, 1);
    chk("flush_out_valid", 64'(out_valid32 | out_valid64), 64'(0));
    chk("flush_in_ready", 64'(in_ready32 & in_ready64), 64'(1));
    cyc(0, 0, 0, 1, 0);
    cyc(1, 32'h12300093, 3'd0, 0, 0);
    cyc(1, 32'h45600093, 3'd0, 0, 0);
    in_valid = 1'b0;
    @(negedge clk) #2 rst_n = 1'b0;
    #1 check_reset("async_reset");
    q.delete();
    @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk) #1;
    check_reset("after_async_reset");
    for (int n = 0; n < 600; n++)
      cyc(1'($urandom_range(0, 3) != 0), $urandom, 3'($urandom_range(0, 7)),
          1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 40) == 0));
    repeat (3) cyc(0, 0, 0, 1, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/imm_gen_pipe.md
# imm_gen_pipe

Registered, handshaked immediate generator for the decode stage of the RISC-V 5-stage pipeline. It extracts and sign-extends I/S/B/U/J immediates to a parametrised XLEN (32 or 64) and adds U-type support. A 2-entry skid buffer with valid/ready flow control lets decode stall without combinational ready paths into fetch. Flush support drops in-flight entries on branch redirect.

## Interface
- INST_WIDTH, 32, instruction width (fixed 32).
- IMM_SEL_WIDTH, 3, immediate select width.
- XLEN, 32, output width; legal values 32 or 64.
- clk  input  1  clock; all logic on rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- flush  input  1  synchronous pipeline flush.
- in_valid  input  1  input entry valid.
- in_ready  output  1  buffer can accept; registered, depends on state only.
- inst  input  INST_WIDTH  instruction word.
- imm_sel  input  IMM_SEL_WIDTH  select: 0=I, 1=S, 2=B, 3=J, 4=U, 5=Z (CSR build only).
- out_valid  output  1  output entry valid.
- out_ready  input  1  consumer accepts.
- imm_out  output  XLEN  sign-extended immediate.
- imm_err  output  1  entry carried an unsupported imm_sel.

## Operation
- Immediate formats, sign bit inst[31] replicated to XLEN:
  - I: inst[31:20].
  - S: {inst[31:25], inst[11:7]}.
  - B: {inst[31], inst[7], inst[30:25], inst[11:8], 0}.
  - J: {inst[31], inst[19:12], inst[20], inst[30:21], 0}.
  - U: {inst[31:12], 12'b0}, sign-extended above bit 31 when XLEN=64.
- Unsupported select: imm=0, imm_err=1.
- Generation is combinational at the input. The result plus imm_err is written into the buffer; outputs are driven only from registers.
- Buffer states:
  - EMPTY: out_valid=0.
  - ONE: main register valid.
  - FULL: main and skid registers valid.
- State transitions:
  - EMPTY→ONE on accept.
  - ONE→EMPTY on pop without accept.
  - ONE stays ONE on simultaneous accept and pop (main reloads).
  - ONE→FULL on accept without pop (entry goes to skid).
  - FULL→ONE on pop (skid moves to main).
- in_ready = (state != FULL). Accept = in_valid & in_ready. Pop = out_valid & out_ready.
- Ordering is strictly FIFO.
- flush: next state EMPTY, both entries discarded, same-cycle input not accepted. flush has priority over accept and pop.
- Reset: state EMPTY, out_valid=0, in_ready=1 after deassertion, imm_out=0, imm_err=0.
- Data registers do not change while their entry is held, i.e. imm_out is stable while out_valid & !out_ready.

## Timing
- Latency 1 cycle: accepted at edge N, visible with out_valid=1 after edge N.
- Throughput 1 entry/cycle when out_ready held high.
- in_ready falls the cycle after the buffer reaches FULL. It rises the cycle after the pop from FULL.
- No combinational path from out_ready to in_ready, or from inputs to outputs.
- rst_n assertion mid-operation clears all state immediately; in-flight entries are lost.

## Configuration
- IMM_GEN_CSR_EN defined: imm_sel=5 (Z) is legal and gives zimm {XLEN-5 zeros, inst[19:15]} with imm_err=0.
- IMM_GEN_CSR_EN undefined: imm_sel=5 is treated as unsupported (imm=0, imm_err=1).

## Test plan
- XLEN=32, I, inst=0xFFF00093, out_ready=1 → one cycle later imm_out=0xFFFFFFFF, imm_err=0. S, inst=0xFE20AE23 → 0xFFFFFFFC.
- U, inst=0x123452B7 → 0x12345000. J, inst=0x001000EF → 0x00000800. XLEN=64, U, inst=0x800002B7 → 0xFFFFFFFF80000000.
- out_ready=0, three back-to-back valid inputs:
  - first two accepted; in_ready=0 from the third cycle; third held.
  - then out_ready=1 → three outputs in order on consecutive cycles, no loss or duplication.
- FULL state, flush=1 with in_valid=1 → next cycle out_valid=0, in_ready=1; flushed and same-cycle data never appear.
- imm_sel=6 → imm_out=0, imm_err=1. imm_sel=5, inst[19:15]=5'h1F → with IMM_GEN_CSR_EN: 0x0000001F, imm_err=0; without: 0, imm_err=1.
- rst_n low while FULL → immediately out_valid=0, imm_out=0; after release in_ready=1 and normal operation resumes.
